// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding, holds a word while
// IF/ID is stalled, and squashes stale fetches after a redirect. Presents a zero NOP when idle.
module if_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [29:0] redirect_pc,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [29:0] PC_out,
   output logic        valid
);

   localparam logic [29:0] ResetPc = 30'h0000_0c00;

   typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

   state_e      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [29:0] tgt_q, tgt_d;
   logic [31:0] buf_q, buf_d;
   logic [29:0] buf_pc_q, buf_pc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StFetch;
         pc_q     <= ResetPc;
         tgt_q    <= '0;
         buf_q    <= '0;
         buf_pc_q <= ResetPc;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         tgt_q    <= tgt_d;
         buf_q    <= buf_d;
         buf_pc_q <= buf_pc_d;
      end
   end

   assign imem_req  = !rst && (state_q != StHold);
   assign imem_addr = pc_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      tgt_d    = tgt_q;
      buf_d    = buf_q;
      buf_pc_d = buf_pc_q;
      valid    = 1'b0;
      instr_out = 32'h0;
      PC_out   = pc_q;

      unique case (state_q)
         StFetch: begin
            valid = imem_ack && !redirect;
            if (valid) instr_out = imem_rdata;
            if (imem_ack) begin
               if (redirect) begin
                  pc_d = redirect_pc;
               end else begin
                  pc_d = pc_q + 30'd1;
                  if (stall) begin
                     buf_d    = imem_rdata;
                     buf_pc_d = pc_q;
                     state_d  = StHold;
                  end
               end
            end else if (redirect) begin
               // pc must stay put: it is the address of the still-outstanding request
               tgt_d   = redirect_pc;
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (redirect) tgt_d = redirect_pc;
            if (imem_ack) begin
               pc_d    = redirect ? redirect_pc : tgt_q;
               state_d = StFetch;
            end
         end
         StHold: begin
            valid  = !redirect;
            PC_out = buf_pc_q;
            if (valid) instr_out = buf_q;
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = StFetch;
            end else if (!stall) begin
               state_d = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

endmodule

// File: tb/tb_if_fetch.sv
// Cycle-by-cycle bench for if_fetch: a table of per-cycle stimulus/expectations pushed through a
// scoreboard queue, plus a hand-written redirect-during-stale-ack sequence.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [29:0] redirect_pc = '0;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [29:0] PC_out;
   logic        valid;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_out   (instr_out),
      .PC_out      (PC_out),
      .valid       (valid)
   );

   function automatic logic [31:0] word(input logic [29:0] a);
      return {a, 2'b11} ^ 32'hC0DE_0000;
   endfunction

   // Address-derived memory contents; garbage when not acking so a leaked word is visible
   assign imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [29:0] rpc;
      logic        ack;
      logic        chk;
      logic        exp_req;
      logic [29:0] exp_addr;
      logic        exp_valid;
      logic [29:0] exp_pc;
   } vec_t;

   typedef struct {
      logic        chk;
      logic        req;
      logic [29:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [29:0] pc;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [29:0] rp,
                               input logic a, input logic c, input logic er,
                               input logic [29:0] ea, input logic ev, input logic [29:0] ep);
      vec_t v;
      v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp; v.ack = a; v.chk = c;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst = v.rst; stall = v.stall; redirect = v.redir; redirect_pc = v.rpc; imem_ack = v.ack;
      e.chk = v.chk; e.req = v.exp_req; e.addr = v.exp_addr; e.valid = v.exp_valid;
      e.pc = v.exp_pc; e.instr = v.exp_valid ? word(v.exp_pc) : 32'h0;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      check("imem_req", {31'b0, imem_req}, {31'b0, e.req});
      if (e.req) check("imem_addr", {2'b0, imem_addr}, {2'b0, e.addr});
      if (e.chk) begin
         check("valid", {31'b0, valid}, {31'b0, e.valid});
         check("instr_out", instr_out, e.instr);
         check("PC_out", {2'b0, PC_out}, {2'b0, e.pc});
      end
      cyc++;
   endtask

   initial begin
      //                rst st rd rpc            ack chk req addr           vld pc
      // reset
      tbl.push_back(mk(1, 0, 0, 30'h0,         0, 0, 0, 30'h0,         0, 30'h0));
      tbl.push_back(mk(1, 0, 0, 30'h0,         0, 1, 0, 30'h0,         0, 30'h0c00));
      // zero-wait memory
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0c00,      1, 30'h0c00));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0c01,      1, 30'h0c01));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0c02,      1, 30'h0c02));
      // 3-wait fetch of 0c03
      tbl.push_back(mk(0, 0, 0, 30'h0,         0, 1, 1, 30'h0c03,      0, 30'h0c03));
      tbl.push_back(mk(0, 0, 0, 30'h0,         0, 1, 1, 30'h0c03,      0, 30'h0c03));
      tbl.push_back(mk(0, 0, 0, 30'h0,         0, 1, 1, 30'h0c03,      0, 30'h0c03));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0c03,      1, 30'h0c03));
      // 0c05 acked under stall, held 3 cycles
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0c04,      1, 30'h0c04));
      tbl.push_back(mk(0, 1, 0, 30'h0,         1, 1, 1, 30'h0c05,      1, 30'h0c05));
      tbl.push_back(mk(0, 1, 0, 30'h0,         0, 1, 0, 30'h0,         1, 30'h0c05));
      tbl.push_back(mk(0, 1, 0, 30'h0,         1, 1, 0, 30'h0,         1, 30'h0c05));
      tbl.push_back(mk(0, 0, 0, 30'h0,         0, 1, 0, 30'h0,         1, 30'h0c05));
      // redirect to 0100 while 0c06 outstanding; stale ack dropped
      tbl.push_back(mk(0, 0, 1, 30'h0100,      0, 1, 1, 30'h0c06,      0, 30'h0c06));
      tbl.push_back(mk(0, 0, 0, 30'h0,         0, 1, 1, 30'h0c06,      0, 30'h0c06));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0c06,      0, 30'h0c06));
      // two redirects during one request: newest (0200) wins
      tbl.push_back(mk(0, 0, 1, 30'h0300,      0, 1, 1, 30'h0100,      0, 30'h0100));
      tbl.push_back(mk(0, 0, 1, 30'h0200,      0, 1, 1, 30'h0100,      0, 30'h0100));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0100,      0, 30'h0100));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0200,      1, 30'h0200));
      // redirect + stall in HOLD discards the buffer
      tbl.push_back(mk(0, 1, 0, 30'h0,         1, 1, 1, 30'h0201,      1, 30'h0201));
      tbl.push_back(mk(0, 1, 1, 30'h0400,      0, 1, 0, 30'h0,         0, 30'h0201));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0400,      1, 30'h0400));
      // ack + redirect in FETCH, then wrap at top of address space
      tbl.push_back(mk(0, 0, 1, 30'h3FFF_FFFF, 1, 1, 1, 30'h0401,      0, 30'h0401));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h3FFF_FFFF, 1, 30'h3FFF_FFFF));
      tbl.push_back(mk(0, 0, 0, 30'h0,         0, 1, 1, 30'h0,         0, 30'h0));
      // reset mid-request abandons it
      tbl.push_back(mk(1, 0, 0, 30'h0,         0, 0, 0, 30'h0,         0, 30'h0));
      tbl.push_back(mk(0, 0, 0, 30'h0,         0, 1, 1, 30'h0c00,      0, 30'h0c00));
      tbl.push_back(mk(0, 0, 0, 30'h0,         1, 1, 1, 30'h0c00,      1, 30'h0c00));

      foreach (tbl[i]) apply(tbl[i]);

      // Redirect coinciding with the stale ack in DROP: that redirect, not tgt, is fetched next
      apply(mk(0, 0, 1, 30'h0500, 0, 1, 1, 30'h0c01, 0, 30'h0c01));
      apply(mk(0, 0, 1, 30'h0600, 1, 1, 1, 30'h0c01, 0, 30'h0c01));
      apply(mk(0, 0, 0, 30'h0,    1, 1, 1, 30'h0600, 1, 30'h0600));
      apply(mk(0, 0, 0, 30'h0,    1, 1, 1, 30'h0601, 1, 30'h0601));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that produces the `instr_in` / `PC_in` pair for the IF/ID pipeline register. It owns the program counter and runs a one-outstanding request/acknowledge handshake to instruction memory. It holds a fetched word in a one-entry buffer while the hazard unit stalls IF/ID, and discards stale fetches on branch or jump redirects. When it has no instruction to present, it supplies a NOP (all zeros), so IF/ID needs no valid bit.

## Interface
- No parameters. Reset PC is fixed: PC[31:2] = 30'h0000_0c00, which is byte address 0x0000_3000.
- Reset is synchronous and active-high, on the single clock `clk`.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  1 = IF/ID will not capture this cycle (the inverse of IF/ID EN).
- redirect  input  1  taken branch or jump; the same source flushes IF/ID.
- redirect_pc  input  30  word address [31:2] of the redirect target.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  30  word address [31:2] of the request.
- imem_ack  input  1  memory accepted and completed the request; data is valid this cycle.
- imem_rdata  input  32  instruction word; sampled only when imem_ack=1.
- instr_out  output  32  instruction to IF/ID `instr_in`; 0 when no valid instruction.
- PC_out  output  30  PC[31:2] to IF/ID `PC_in`.
- valid  output  1  1 = instr_out/PC_out carry a real instruction this cycle.

## Operation
- Registers:
  - pc[31:2]: next address to fetch.
  - tgt[31:2]: pending redirect target.
  - buf[31:0], buf_pc[31:2]: hold buffer.
  - state ∈ {FETCH, HOLD, DROP}.
- Reset values: state=FETCH, pc=30'h0c00, tgt=0, buf=0, buf_pc=30'h0c00.
- imem_req = !rst && state != HOLD.
- imem_addr = pc. It stays stable from the first cycle of a request until its ack.
- Only one request is outstanding at a time, and memory latency is unbounded. The ack may arrive in the same cycle imem_req first rises.
- A word is "consumed" in a cycle when valid=1 and stall=0.
- FETCH state:
  - Presented outputs: valid = imem_ack && !redirect; instr_out = imem_rdata; PC_out = pc.
  - ack && redirect: pc <= redirect_pc; state stays FETCH; the returned data is dropped.
  - ack && !redirect && stall: buf <= imem_rdata; buf_pc <= pc; pc <= pc+1; go to HOLD.
  - ack && !redirect && !stall: pc <= pc+1; stay in FETCH. The next request is issued the following cycle.
  - !ack && redirect: tgt <= redirect_pc; go to DROP. pc must not change while the request is outstanding.
- DROP state (a stale request is outstanding):
  - Presented outputs: valid=0.
  - redirect (with or without ack): tgt <= redirect_pc. The newest redirect wins.
  - On ack: pc <= (redirect ? redirect_pc : tgt); go to FETCH. The returned data is never presented.
- HOLD state:
  - Presented outputs: valid = !redirect; instr_out = buf; PC_out = buf_pc.
  - imem_req=0 in this state.
  - redirect: pc <= redirect_pc; go to FETCH; the buffer is discarded.
  - !redirect && !stall: the buffer is consumed; go to FETCH.
  - !redirect && stall: remain in HOLD.
- Whenever valid=0: instr_out=32'h0 and PC_out=pc (in HOLD, PC_out=buf_pc).
- Arithmetic: pc+1 is a 30-bit increment that wraps from 30'h3FFF_FFFF to 0.
- imem_ack while imem_req=0 is a protocol error and is ignored.

## Timing
- Outputs during and immediately after a reset cycle: imem_req=0, valid=0, instr_out=0, PC_out=30'h0c00.
- The first request is imem_req=1, imem_addr=30'h0c00, in the first cycle with rst=0.
- Latency:
  - With zero-wait memory (ack in the same cycle as req) and no stall, one instruction is presented every cycle.
  - Ack to presentation is combinational, in the same cycle.
  - After a redirect with no fetch outstanding, the target request issues the next cycle.
  - After a redirect with a fetch outstanding, the target request issues the cycle after the stale ack.
- Priority rules:
  - redirect beats stall.
  - rst beats everything.
  - rst during an outstanding request: the request is abandoned. The memory side must also be reset in the same cycle.
- Paths from imem_ack, redirect and stall to the outputs are combinational. No output depends combinationally on rst other than imem_req.

## Test plan
- Reset, then zero-wait memory returning addr-based words, stall=0: fetch from 30'h0c00 begins in the first cycle after reset; instr/PC pairs 0c00, 0c01, 0c02 appear on consecutive cycles with valid=1.
- 3-wait memory, stall=0: imem_addr=0c00 is held for 4 cycles; valid=1 only on the ack cycle; instr_out=0 and valid=0 on the other cycles.
- Ack for 0c05 with stall=1 for 3 cycles: HOLD presents buf/0c05 for 3 cycles with imem_req=0; the word is consumed when stall drops; the request for 0c06 follows the next cycle.
- Redirect to 30'h0100 while a 4-wait fetch of 0c02 is outstanding: DROP state; the stale ack is not presented (valid=0); the next request has imem_addr=30'h0100.
- Two redirects, to 0100 then 0200, during one outstanding request: the fetch after the stale ack goes to 0200. Redirect and stall asserted together in HOLD: the buffer is discarded and the fetch goes to redirect_pc.
- pc=30'h3FFF_FFFF is acked and consumed: the next imem_addr is 30'h0000_0000. rst asserted mid-request: the next outputs match the reset values above.
